noc_packet_checker: RTL and testbench
=====================================

NOC_PACKET_CHECKER -- requirements
Module: noc_packet_checker

Interface
REQ-001 SHALL have parameter X_ID, default 0, meaning the node's own X coordinate (width Noc_ID_X_Width).
REQ-002 SHALL have parameter Y_ID, default 0, meaning the node's own Y coordinate (width Noc_ID_Y_Width).
REQ-003 SHALL have parameter MAX_DATA, default 16, meaning the maximum number of data flits accepted per packet.
REQ-004 SHALL have port noc_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port noc_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port receive_valid, input, 1 bit: an upstream flit is present.
REQ-007 SHALL have port receive_ready, output, 1 bit: the checker accepts a flit this cycle.
REQ-008 SHALL have port receive_flit, input, Noc_Data_Width bits: the flit payload.
REQ-009 SHALL have ports receive_is_header and receive_is_tail, input, 1 bit each: the flit-type sideband signals.
REQ-010 SHALL have port pkt_done, output, 1 bit: a one-cycle pulse marking packet completion (good or bad).
REQ-011 SHALL have ports pkt_src_x and pkt_src_y, output, ID widths: the source of the last completed packet.
REQ-012 SHALL have port pkt_len, output, 8 bits: the data-flit count of the last packet.
REQ-013 SHALL have port pkt_err, output, 3 bits: the error code of the last packet (0 means OK).
REQ-014 SHALL have ports good_cnt and bad_cnt, output, 16 bits each: running packet counters.

Function
REQ-015 SHALL count a transfer only on a cycle where receive_valid and receive_ready are both 1.
REQ-016 SHALL implement the states IDLE, BODY, DRAIN and REPORT.
REQ-017 IDLE: on a header transfer, SHALL latch the source ID from [Noc_Point_H-1:Noc_Source_Point], clear the data count, and go to BODY.
REQ-018 IDLE: SHALL drop a non-header transfer and raise error 6 (stray flit), going to REPORT.
REQ-019 Header checks SHALL be done in the transfer cycle; on the first failure go to DRAIN with the error recorded.
REQ-020 Header check: the H field [Noc_Data_Width-1:Noc_Point_H] SHALL equal Noc_Head_H and the E field [Axi_Len_Point-1:Noc_Point_E] SHALL equal Noc_Head_E; otherwise error 1.
REQ-021 Header check: the destination field (the ID-width slice directly below the source field) SHALL equal {X_ID,Y_ID}; otherwise error 2.
REQ-022 Header precedence: SHALL report error 1 before error 2.
REQ-023 BODY: a data transfer SHALL increment the data count; the transfer that would make the count exceed MAX_DATA SHALL raise error 4 and go to DRAIN.
REQ-024 BODY: a header transfer SHALL raise error 5 and go to DRAIN; that header is discarded.
REQ-025 BODY: on a tail transfer, SHALL check that the H field equals Noc_Tail_H, the E field equals Noc_Tail_E, and the source equals the latched source; any mismatch raises error 3. Then go to REPORT.
REQ-026 DRAIN: SHALL discard flits until a tail transfer, then go to REPORT with the recorded error.
REQ-027 REPORT: SHALL last exactly one cycle, hold receive_ready=0, pulse pkt_done=1, update the pkt_* outputs, increment good_cnt (if pkt_err=0) or bad_cnt, then return to IDLE.
REQ-028 receive_ready SHALL be 1 in every state except REPORT.
REQ-029 Counters SHALL saturate at 16'hFFFF.
REQ-030 The latency from a tail transfer (cycle N) to the pkt_done pulse SHALL be: pulse visible in cycle N+1.
REQ-031 A header-and-tail flit (both sideband bits set) in IDLE SHALL be checked as a header and immediately as a tail, giving a zero-length packet and going to REPORT.

Reset
REQ-032 On noc_rst_n=0: state=IDLE, receive_ready=1, pkt_done=0, pkt_src_x/y=0, pkt_len=0, pkt_err=0, good_cnt=0, bad_cnt=0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet with no pkt_done pulse and no counter change.

Structure
REQ-034 The flit field positions, the marker constants and the error-code constants (1..6) SHALL live in the shared Noc_parameters.v; none are local literals.
REQ-035 A sub-module noc_flit_field_decode (combinational: H/E hits, source, destination) SHALL be instantiated once.

Verification
REQ-036 Bench: X_ID=1, Y_ID=2; good packet header(src 0,0 dst 1,2), 3 data flits, tail -> pkt_done one cycle after the tail, pkt_err=0, pkt_len=3, good_cnt=1.
REQ-037 Bench: header with dst 2,2 -> flits drained to the tail, pkt_err=2, bad_cnt=1.
REQ-038 Bench: MAX_DATA=4, 5 data flits -> pkt_err=4 on the fifth; the rest is drained and pkt_done follows the tail.
REQ-039 Bench: tail whose source is 3,3 after a header with source 0,0 -> pkt_err=3.
REQ-040 Bench: data flit in IDLE -> pkt_err=6; header in BODY -> pkt_err=5.
REQ-041 Bench: reset pulse after 2 data flits, then a good packet -> good_cnt=1, bad_cnt=0, and exactly one pkt_done.

Source files
------------

// File: rtl/noc_packet_checker_pkg.sv
// -----------------------------------------------------------------------------
// noc_packet_checker_pkg
// Shared NoC flit layout, marker constants, error codes and FSM encoding used
// by the packet checker and its field decoder.
//
// Flit layout (Noc_Data_Width = 16):
//   [15:12] H field     marker nibble (header / tail)
//   [11: 8] source ID   {x[1:0], y[1:0]}
//   [ 7: 4] dest ID     {x[1:0], y[1:0]}
//   [ 3: 0] E field     marker nibble (header / tail)
// -----------------------------------------------------------------------------
package noc_packet_checker_pkg;

  localparam int Noc_Data_Width   = 16;
  localparam int Noc_ID_X_Width   = 2;
  localparam int Noc_ID_Y_Width   = 2;
  localparam int Noc_ID_Width     = Noc_ID_X_Width + Noc_ID_Y_Width;

  localparam int Noc_Point_H      = 12;
  localparam int Noc_Source_Point = Noc_Point_H - Noc_ID_Width;
  localparam int Noc_Dest_Point   = Noc_Source_Point - Noc_ID_Width;
  localparam int Axi_Len_Point    = Noc_Dest_Point;
  localparam int Noc_Point_E      = 0;

  localparam int Noc_H_Width      = Noc_Data_Width - Noc_Point_H;
  localparam int Noc_E_Width      = Axi_Len_Point - Noc_Point_E;

  localparam logic [Noc_H_Width-1:0] Noc_Head_H = 4'hA;
  localparam logic [Noc_E_Width-1:0] Noc_Head_E = 4'h5;
  localparam logic [Noc_H_Width-1:0] Noc_Tail_H = 4'hC;
  localparam logic [Noc_E_Width-1:0] Noc_Tail_E = 4'h3;

  localparam int Noc_Len_Width    = 8;
  localparam int Noc_Cnt_Width    = 16;
  localparam int Noc_Err_Width    = 3;

  localparam logic [Noc_Err_Width-1:0] Noc_Err_None     = 3'd0;
  localparam logic [Noc_Err_Width-1:0] Noc_Err_Head     = 3'd1;
  localparam logic [Noc_Err_Width-1:0] Noc_Err_Dest     = 3'd2;
  localparam logic [Noc_Err_Width-1:0] Noc_Err_Tail     = 3'd3;
  localparam logic [Noc_Err_Width-1:0] Noc_Err_Overflow = 3'd4;
  localparam logic [Noc_Err_Width-1:0] Noc_Err_HeadBody = 3'd5;
  localparam logic [Noc_Err_Width-1:0] Noc_Err_Stray    = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BODY,
    ST_DRAIN,
    ST_REPORT
  } chkState_t;

  // Packet counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [Noc_Cnt_Width-1:0] satInc(input logic [Noc_Cnt_Width-1:0] value);
    return (value == {Noc_Cnt_Width{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/noc_packet_checker_flit_decode.sv
// -----------------------------------------------------------------------------
// noc_flit_field_decode
// Purely combinational slicing of a flit into marker hits and ID fields.
//
// Ports:
//   flit_i      flit payload
//   headHit_o   H and E fields both carry the header markers
//   tailHit_o   H and E fields both carry the tail markers
//   src_o       source ID field {x, y}
//   dst_o       destination ID field {x, y}
// -----------------------------------------------------------------------------
module noc_flit_field_decode
  import noc_packet_checker_pkg::*;
(
  input  logic [Noc_Data_Width-1:0] flit_i,
  output logic                      headHit_o,
  output logic                      tailHit_o,
  output logic [Noc_ID_Width-1:0]   src_o,
  output logic [Noc_ID_Width-1:0]   dst_o
);

  logic [Noc_H_Width-1:0] hField;
  logic [Noc_E_Width-1:0] eField;

  assign hField = flit_i[Noc_Data_Width-1:Noc_Point_H];
  assign eField = flit_i[Axi_Len_Point-1:Noc_Point_E];
  assign src_o  = flit_i[Noc_Point_H-1:Noc_Source_Point];
  assign dst_o  = flit_i[Noc_Source_Point-1:Noc_Dest_Point];

  assign headHit_o = (hField == Noc_Head_H) && (eField == Noc_Head_E);
  assign tailHit_o = (hField == Noc_Tail_H) && (eField == Noc_Tail_E);

endmodule

// File: rtl/noc_packet_checker.sv
// -----------------------------------------------------------------------------
// noc_packet_checker
// Consumes NoC packets, validates header/tail markers, destination, source
// consistency and data length, and reports each completed packet with a
// one-cycle pkt_done pulse plus saturating good/bad packet counters.
//
// Ports:
//   noc_clk, noc_rst_n                 clock, async active-low reset
//   receive_valid/ready/flit           upstream flit handshake
//   receive_is_header/is_tail          flit-type sideband
//   pkt_done                           one-cycle completion pulse
//   pkt_src_x/y, pkt_len, pkt_err      summary of the last completed packet
//   good_cnt, bad_cnt                  saturating packet counters
// -----------------------------------------------------------------------------
module noc_packet_checker
  import noc_packet_checker_pkg::*;
#(
  parameter logic [Noc_ID_X_Width-1:0] X_ID     = '0,
  parameter logic [Noc_ID_Y_Width-1:0] Y_ID     = '0,
  parameter int unsigned               MAX_DATA = 16
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic                      receive_valid,
  output logic                      receive_ready,
  input  logic [Noc_Data_Width-1:0] receive_flit,
  input  logic                      receive_is_header,
  input  logic                      receive_is_tail,
  output logic                      pkt_done,
  output logic [Noc_ID_X_Width-1:0] pkt_src_x,
  output logic [Noc_ID_Y_Width-1:0] pkt_src_y,
  output logic [Noc_Len_Width-1:0]  pkt_len,
  output logic [Noc_Err_Width-1:0]  pkt_err,
  output logic [Noc_Cnt_Width-1:0]  good_cnt,
  output logic [Noc_Cnt_Width-1:0]  bad_cnt
);

  localparam logic [Noc_ID_Width-1:0]  OwnId   = {X_ID, Y_ID};
  localparam logic [Noc_Len_Width-1:0] MaxData = Noc_Len_Width'(MAX_DATA);

  chkState_t                 state_q, state_d;
  logic [Noc_Err_Width-1:0]  err_q,   err_d;
  logic [Noc_Len_Width-1:0]  len_q,   len_d;
  logic [Noc_ID_Width-1:0]   src_q,   src_d;

  logic [Noc_ID_Width-1:0]   pktSrc_q;
  logic [Noc_Len_Width-1:0]  pktLen_q;
  logic [Noc_Err_Width-1:0]  pktErr_q;
  logic [Noc_Cnt_Width-1:0]  goodCnt_q;
  logic [Noc_Cnt_Width-1:0]  badCnt_q;

  logic                      headHit;
  logic                      tailHit;
  logic [Noc_ID_Width-1:0]   flitSrc;
  logic [Noc_ID_Width-1:0]   flitDst;
  logic                      xfer;
  logic                      reportEntry;

  noc_flit_field_decode u_decode (
    .flit_i    (receive_flit),
    .headHit_o (headHit),
    .tailHit_o (tailHit),
    .src_o     (flitSrc),
    .dst_o     (flitDst)
  );

  assign xfer        = receive_valid && receive_ready;
  assign reportEntry = (state_d == ST_REPORT) && (state_q != ST_REPORT);

  // State and per-packet working registers.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= Noc_Err_None;
      len_q   <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      len_q   <= len_d;
      src_q   <= src_d;
    end
  end

  // Next-state and working-register update. A header+tail flit is checked
  // with the header markers only; its source trivially matches itself, so
  // it completes as a zero-length packet with whatever header error it has.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    len_d   = len_q;
    src_d   = src_q;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          len_d = '0;
          if (receive_is_header) begin
            src_d = flitSrc;
            if (!headHit) begin
              err_d = Noc_Err_Head;
            end else if (flitDst != OwnId) begin
              err_d = Noc_Err_Dest;
            end else begin
              err_d = Noc_Err_None;
            end
            if (receive_is_tail) begin
              state_d = ST_REPORT;
            end else if (err_d != Noc_Err_None) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_BODY;
            end
          end else begin
            err_d   = Noc_Err_Stray;
            state_d = ST_REPORT;
          end
        end
      end
      ST_BODY: begin
        if (xfer) begin
          if (receive_is_header) begin
            err_d   = Noc_Err_HeadBody;
            state_d = ST_DRAIN;
          end else if (receive_is_tail) begin
            err_d   = (tailHit && (flitSrc == src_q)) ? Noc_Err_None : Noc_Err_Tail;
            state_d = ST_REPORT;
          end else if (len_q == MaxData) begin
            err_d   = Noc_Err_Overflow;
            state_d = ST_DRAIN;
          end else begin
            len_d = len_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (xfer && receive_is_tail) begin
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake and completion pulse depend only on the current state.
  always_comb begin
    receive_ready = (state_q != ST_REPORT);
    pkt_done      = (state_q == ST_REPORT);
  end

  // Packet summary and counters are captured on the edge that enters
  // REPORT, so they are already valid during the pkt_done cycle.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      pktSrc_q  <= '0;
      pktLen_q  <= '0;
      pktErr_q  <= Noc_Err_None;
      goodCnt_q <= '0;
      badCnt_q  <= '0;
    end else if (reportEntry) begin
      pktSrc_q <= src_d;
      pktLen_q <= len_d;
      pktErr_q <= err_d;
      if (err_d == Noc_Err_None) begin
        goodCnt_q <= satInc(goodCnt_q);
      end else begin
        badCnt_q <= satInc(badCnt_q);
      end
    end
  end

  assign pkt_src_x = pktSrc_q[Noc_ID_Width-1:Noc_ID_Y_Width];
  assign pkt_src_y = pktSrc_q[Noc_ID_Y_Width-1:0];
  assign pkt_len   = pktLen_q;
  assign pkt_err   = pktErr_q;
  assign good_cnt  = goodCnt_q;
  assign bad_cnt   = badCnt_q;

endmodule

// File: tb/tb_noc_packet_checker.sv
// -----------------------------------------------------------------------------
// tb_noc_packet_checker
// Directed packet sequences against a node at X=1, Y=2 with MAX_DATA=4.
// Expected packet reports are queued by the stimulus and consumed by an
// independent monitor whenever pkt_done is seen.
// -----------------------------------------------------------------------------
module tb_noc_packet_checker;

  localparam logic [3:0] HEAD_H = 4'hA;
  localparam logic [3:0] HEAD_E = 4'h5;
  localparam logic [3:0] TAIL_H = 4'hC;
  localparam logic [3:0] TAIL_E = 4'h3;

  typedef struct {
    logic [2:0]  err;
    logic [7:0]  len;
    logic [1:0]  sx;
    logic [1:0]  sy;
    logic        chkSrc;
    logic [15:0] good;
    logic [15:0] bad;
  } expPkt_t;

  logic        noc_clk;
  logic        noc_rst_n;
  logic        receive_valid;
  logic        receive_ready;
  logic [15:0] receive_flit;
  logic        receive_is_header;
  logic        receive_is_tail;
  logic        pkt_done;
  logic [1:0]  pkt_src_x;
  logic [1:0]  pkt_src_y;
  logic [7:0]  pkt_len;
  logic [2:0]  pkt_err;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  expPkt_t expQ[$];
  int      vectors     = 0;
  int      miscompares = 0;
  int      doneSeen    = 0;

  noc_packet_checker #(
    .X_ID     (2'd1),
    .Y_ID     (2'd2),
    .MAX_DATA (4)
  ) dut (
    .noc_clk           (noc_clk),
    .noc_rst_n         (noc_rst_n),
    .receive_valid     (receive_valid),
    .receive_ready     (receive_ready),
    .receive_flit      (receive_flit),
    .receive_is_header (receive_is_header),
    .receive_is_tail   (receive_is_tail),
    .pkt_done          (pkt_done),
    .pkt_src_x         (pkt_src_x),
    .pkt_src_y         (pkt_src_y),
    .pkt_len           (pkt_len),
    .pkt_err           (pkt_err),
    .good_cnt          (good_cnt),
    .bad_cnt           (bad_cnt)
  );

  // Free-running 100 MHz clock.
  initial begin
    noc_clk = 1'b0;
    forever #5 noc_clk = ~noc_clk;
  end

  // One comparison: counts it, and reports a miscompare with both values.
  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] mkHead(input logic [1:0] sx, sy, dx, dy);
    return {HEAD_H, sx, sy, dx, dy, HEAD_E};
  endfunction

  function automatic logic [15:0] mkTail(input logic [1:0] sx, sy);
    return {TAIL_H, sx, sy, 4'h0, TAIL_E};
  endfunction

  task automatic pushExp(input logic [2:0] err, input logic [7:0] len, input logic [1:0] sx, sy,
                         input logic chkSrc, input logic [15:0] good, bad);
    expPkt_t e;
    e.err = err; e.len = len; e.sx = sx; e.sy = sy;
    e.chkSrc = chkSrc; e.good = good; e.bad = bad;
    expQ.push_back(e);
  endtask

  // Offers one flit, waits (bounded) for it to be accepted, then checks
  // whether pkt_done appears in the very next cycle.
  task automatic applyStimulus(input logic hdr, input logic tl, input logic [15:0] flit, input logic expDone);
    int guard = 0;
    while (!receive_ready && guard < 20) begin
      @(posedge noc_clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      checkOutput("ready_timeout", 16'(receive_ready), 16'h1);
    end
    receive_valid     = 1'b1;
    receive_flit      = flit;
    receive_is_header = hdr;
    receive_is_tail   = tl;
    @(posedge noc_clk); #1;
    receive_valid     = 1'b0;
    receive_is_header = 1'b0;
    receive_is_tail   = 1'b0;
    checkOutput("done_latency", 16'(pkt_done), 16'(expDone));
  endtask

  task automatic sendData(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0F0F ^ 16'(i), 1'b0);
    end
  endtask

  // Monitor: every pkt_done pulse pops one expected report and compares it.
  always @(negedge noc_clk) begin
    if (noc_rst_n && pkt_done) begin
      expPkt_t e;
      doneSeen++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 16'h1, 16'h0);
      end else begin
        e = expQ.pop_front();
        checkOutput("pkt_err", 16'(pkt_err), 16'(e.err));
        checkOutput("pkt_len", 16'(pkt_len), 16'(e.len));
        checkOutput("good_cnt", good_cnt, e.good);
        checkOutput("bad_cnt", bad_cnt, e.bad);
        if (e.chkSrc) begin
          checkOutput("pkt_src", 16'({pkt_src_x, pkt_src_y}), 16'({e.sx, e.sy}));
        end
      end
    end
  end

  task automatic checkResetState();
    checkOutput("rst_ready", 16'(receive_ready), 16'h1);
    checkOutput("rst_done", 16'(pkt_done), 16'h0);
    checkOutput("rst_src", 16'({pkt_src_x, pkt_src_y}), 16'h0);
    checkOutput("rst_len", 16'(pkt_len), 16'h0);
    checkOutput("rst_err", 16'(pkt_err), 16'h0);
    checkOutput("rst_good", good_cnt, 16'h0);
    checkOutput("rst_bad", bad_cnt, 16'h0);
  endtask

  // Directed packet sequence.
  initial begin
    noc_rst_n         = 1'b0;
    receive_valid     = 1'b0;
    receive_flit      = '0;
    receive_is_header = 1'b0;
    receive_is_tail   = 1'b0;
    repeat (3) @(posedge noc_clk);
    #1;
    checkResetState();
    noc_rst_n = 1'b1;
    @(posedge noc_clk); #1;

    // Good packet from (0,0), three data flits.
    applyStimulus(1'b1, 1'b0, mkHead(2'd0, 2'd0, 2'd1, 2'd2), 1'b0);
    sendData(3);
    pushExp(3'd0, 8'd3, 2'd0, 2'd0, 1'b1, 16'd1, 16'd0);
    applyStimulus(1'b0, 1'b1, mkTail(2'd0, 2'd0), 1'b1);

    // Wrong destination (2,2): drained to the tail.
    applyStimulus(1'b1, 1'b0, mkHead(2'd0, 2'd0, 2'd2, 2'd2), 1'b0);
    sendData(2);
    pushExp(3'd2, 8'd0, 2'd0, 2'd0, 1'b1, 16'd1, 16'd1);
    applyStimulus(1'b0, 1'b1, mkTail(2'd0, 2'd0), 1'b1);

    // Length overflow: fifth data flit flags, the rest drains.
    applyStimulus(1'b1, 1'b0, mkHead(2'd1, 2'd1, 2'd1, 2'd2), 1'b0);
    sendData(6);
    pushExp(3'd4, 8'd4, 2'd1, 2'd1, 1'b1, 16'd1, 16'd2);
    applyStimulus(1'b0, 1'b1, mkTail(2'd1, 2'd1), 1'b1);

    // Tail claiming source (3,3) after header from (0,0).
    applyStimulus(1'b1, 1'b0, mkHead(2'd0, 2'd0, 2'd1, 2'd2), 1'b0);
    sendData(1);
    pushExp(3'd3, 8'd1, 2'd0, 2'd0, 1'b1, 16'd1, 16'd3);
    applyStimulus(1'b0, 1'b1, mkTail(2'd3, 2'd3), 1'b1);

    // Stray data flit in IDLE.
    pushExp(3'd6, 8'd0, 2'd0, 2'd0, 1'b0, 16'd1, 16'd4);
    applyStimulus(1'b0, 1'b0, 16'h1234, 1'b1);

    // Second header inside a packet.
    applyStimulus(1'b1, 1'b0, mkHead(2'd0, 2'd0, 2'd1, 2'd2), 1'b0);
    sendData(1);
    applyStimulus(1'b1, 1'b0, mkHead(2'd0, 2'd0, 2'd1, 2'd2), 1'b0);
    sendData(1);
    pushExp(3'd5, 8'd1, 2'd0, 2'd0, 1'b1, 16'd1, 16'd5);
    applyStimulus(1'b0, 1'b1, mkTail(2'd0, 2'd0), 1'b1);

    // Bad header marker and bad destination together: marker error wins.
    applyStimulus(1'b1, 1'b0, 16'hB0A5, 1'b0);
    sendData(1);
    pushExp(3'd1, 8'd0, 2'd0, 2'd0, 1'b1, 16'd1, 16'd6);
    applyStimulus(1'b0, 1'b1, mkTail(2'd0, 2'd0), 1'b1);

    // Single header+tail flit: zero-length good packet.
    pushExp(3'd0, 8'd0, 2'd0, 2'd0, 1'b1, 16'd2, 16'd6);
    applyStimulus(1'b1, 1'b1, mkHead(2'd0, 2'd0, 2'd1, 2'd2), 1'b1);

    // Tail with a corrupted H marker.
    applyStimulus(1'b1, 1'b0, mkHead(2'd0, 2'd0, 2'd1, 2'd2), 1'b0);
    pushExp(3'd3, 8'd0, 2'd0, 2'd0, 1'b1, 16'd2, 16'd7);
    applyStimulus(1'b0, 1'b1, 16'hD003, 1'b1);

    // Reset mid-packet, then one good packet from (2,1).
    applyStimulus(1'b1, 1'b0, mkHead(2'd0, 2'd0, 2'd1, 2'd2), 1'b0);
    sendData(2);
    #2;
    noc_rst_n = 1'b0;
    @(posedge noc_clk); #1;
    checkResetState();
    doneSeen  = 0;
    noc_rst_n = 1'b1;
    @(posedge noc_clk); #1;
    applyStimulus(1'b1, 1'b0, mkHead(2'd2, 2'd1, 2'd1, 2'd2), 1'b0);
    sendData(2);
    pushExp(3'd0, 8'd2, 2'd2, 2'd1, 1'b1, 16'd1, 16'd0);
    applyStimulus(1'b0, 1'b1, mkTail(2'd2, 2'd1), 1'b1);

    repeat (4) @(posedge noc_clk);
    #1;
    checkOutput("done_after_reset", 16'(doneSeen), 16'd1);
    checkOutput("pending_reports", 16'(expQ.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
